// File: rtl/subleq_core.sv
// SUBLEQ sequencer/datapath: fetches A,B,C at pc, writes mem[B]-mem[A] back to B and
// branches to C when the result is <= 0. Sole master of the shared async RAM bus.
`timescale 1ns/1ps
module subleq_core #(
  parameter logic [7:0] PC_RESET  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_ope,
  output logic       mem_ctl,
  output logic       mem_ena,
  output logic [7:0] mem_adr,
  inout  wire  [7:0] mem_dat,
  output logic [7:0] pc,
  output logic       halted,
  output logic       instr_done
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_FA   = 4'd1;
  localparam logic [3:0] S_FB   = 4'd2;
  localparam logic [3:0] S_FC   = 4'd3;
  localparam logic [3:0] S_RA   = 4'd4;
  localparam logic [3:0] S_RB   = 4'd5;
  localparam logic [3:0] S_WS   = 4'd6;
  localparam logic [3:0] S_WL   = 4'd7;
  localparam logic [3:0] S_WH   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  logic [3:0] state_r, state_nxt_s;
  logic [7:0] pc_r, pc_nxt_s;
  logic [7:0] a_r, b_r, c_r, va_r, vb_r;
  logic [7:0] res_s, adr_s, adr_r;
  logic       leq_s, ope_s, ctl_s, ena_s, oe_s;
  logic       ope_r, ctl_r, ena_r, oe_r, halted_r, done_r;

  // SUBLEQ branch condition on an 8-bit two's-complement result
  function automatic logic leq_f(input logic [7:0] r);
    return (r == 8'h00) | r[7];
  endfunction

  assign res_s = vb_r - va_r;
  assign leq_s = leq_f(res_s);

  // next state and next pc
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt_s = S_FA;
          pc_nxt_s    = PC_RESET;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_FA: state_nxt_s = S_FB;
      S_FB: state_nxt_s = S_FC;
      S_FC: state_nxt_s = S_RA;
      S_RA: state_nxt_s = S_RB;
      S_RB: state_nxt_s = S_WS;
      S_WS: state_nxt_s = S_WL;
      S_WL: state_nxt_s = S_WH;
      S_WH: begin
        if (leq_s && (c_r == HALT_ADDR)) begin
          state_nxt_s = S_HALT;
        end else if (leq_s) begin
          state_nxt_s = S_FA;
          pc_nxt_s    = c_r;
        end else begin
          state_nxt_s = S_FA;
          pc_nxt_s    = pc_r + 8'd3;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so the registers hold the value of the state being entered
  always_comb begin
    ope_s = 1'b1;
    ctl_s = 1'b1;
    ena_s = 1'b1;
    oe_s  = 1'b0;
    adr_s = 8'h00;
    case (state_nxt_s)
      S_FA: begin adr_s = pc_nxt_s;     ope_s = 1'b0; ena_s = 1'b0; end
      S_FB: begin adr_s = pc_r + 8'd1;  ope_s = 1'b0; ena_s = 1'b0; end
      S_FC: begin adr_s = pc_r + 8'd2;  ope_s = 1'b0; ena_s = 1'b0; end
      S_RA: begin adr_s = a_r;          ope_s = 1'b0; ena_s = 1'b0; end
      S_RB: begin adr_s = b_r;          ope_s = 1'b0; ena_s = 1'b0; end
      S_WS: begin adr_s = b_r;          ena_s = 1'b0; oe_s = 1'b1; end
      S_WL: begin adr_s = b_r;          ena_s = 1'b0; oe_s = 1'b1; ctl_s = 1'b0; end
      S_WH: begin adr_s = b_r; end
      default: adr_s = 8'h00;
    endcase
  end

  // state, pc and registered bus strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      pc_r     <= PC_RESET;
      ope_r    <= 1'b1;
      ctl_r    <= 1'b1;
      ena_r    <= 1'b1;
      oe_r     <= 1'b0;
      adr_r    <= 8'h00;
      halted_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      ope_r    <= ope_s;
      ctl_r    <= ctl_s;
      ena_r    <= ena_s;
      oe_r     <= oe_s;
      adr_r    <= adr_s;
      halted_r <= (state_nxt_s == S_HALT);
      done_r   <= (state_r == S_WH);
    end
  end

  // operand capture at the exit edge of each read cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= 8'h00;
      b_r  <= 8'h00;
      c_r  <= 8'h00;
      va_r <= 8'h00;
      vb_r <= 8'h00;
    end else begin
      case (state_r)
        S_FA:    a_r  <= mem_dat;
        S_FB:    b_r  <= mem_dat;
        S_FC:    c_r  <= mem_dat;
        S_RA:    va_r <= mem_dat;
        S_RB:    vb_r <= mem_dat;
        default: a_r  <= a_r;
      endcase
    end
  end

  // write data comes straight from the operand registers, stable since RB exit
  assign mem_dat    = oe_r ? res_s : 8'hzz;
  assign mem_ope    = ope_r;
  assign mem_ctl    = ctl_r;
  assign mem_ena    = ena_r;
  assign mem_adr    = adr_r;
  assign pc         = pc_r;
  assign halted     = halted_r;
  assign instr_done = done_r;

endmodule
